alarm_tone_sequencer: RTL and testbench

Downstream consumer of the clock top level's alarm-match flag. It turns the level alarm indication into a timed ring sequence: a square-wave tone gated by an on/off beep cadence, with snooze and stop handling and an auto-silence timeout. It drives the board buzzer pin and the status LEDs, and replaces the direct flag-to-buzzer path.

---
 rtl/alarm_pkg.sv | 16 +
 rtl/tone_divider.sv | 32 +++
 rtl/alarm_tone_sequencer.sv | 116 +++++++++++
 tb/tb_alarm_tone_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared state encoding and default timing constants
// for the alarm tone sequencer.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    localparam int unsigned DEF_TONE_DIV  = 25000;
    localparam int unsigned DEF_BEEP_DIV  = 25000000;
    localparam int unsigned DEF_TIMEOUT_S = 60;
    localparam int unsigned DEF_SNOOZE_S  = 300;

endpackage

// File: rtl/tone_divider.sv
// Half-period counter: q toggles every DIV enabled cycles.
// clear restarts the count and returns q to INIT.
module tone_divider #(
    parameter int unsigned DIV  = 4,
    parameter logic        INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic q
);

    localparam int unsigned W = $clog2(DIV + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
            q   <= INIT;
        end else if (en) begin
            if (cnt == W'(DIV - 1)) begin
                cnt <= '0;
                q   <= ~q;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/alarm_tone_sequencer.sv
// Turns the alarm-match level into a timed ring sequence with
// beep cadence, snooze, stop and auto-silence timeout.
module alarm_tone_sequencer
    import alarm_pkg::*;
#(
    parameter int unsigned TONE_DIV  = DEF_TONE_DIV,
    parameter int unsigned BEEP_DIV  = DEF_BEEP_DIV,
    parameter int unsigned TIMEOUT_S = DEF_TIMEOUT_S,
    parameter int unsigned SNOOZE_S  = DEF_SNOOZE_S
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic alarm_in,
    input  logic snooze,
    input  logic stop,
    input  logic tick_1hz,
    output logic sound,
    output logic ringing,
    output logic snoozing,
    output logic beep_led
);

    localparam int unsigned SEC_MAX =
        (TIMEOUT_S > SNOOZE_S) ? TIMEOUT_S : SNOOZE_S;
    localparam int unsigned SW = $clog2(SEC_MAX + 1);

    state_t        state;
    state_t        state_nx;
    logic          alarm_q;
    logic          rise;
    logic          in_ring;
    logic          ring_entry;
    logic          tone_q;
    logic          beep_on;
    logic [SW-1:0] sec;

    assign rise       = alarm_in & ~alarm_q;
    assign in_ring    = (state == ST_RING);
    assign ring_entry = (state_nx == ST_RING) && !in_ring;

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (rise) state_nx = ST_RING;
                end
                ST_RING: begin
                    if (stop)
                        state_nx = ST_IDLE;
                    else if (snooze)
                        state_nx = ST_SNOOZE;
                    else if (tick_1hz && sec == SW'(TIMEOUT_S - 1))
                        state_nx = ST_IDLE;
                end
                ST_SNOOZE: begin
                    if (stop)
                        state_nx = ST_IDLE;
                    else if (tick_1hz && sec == SW'(SNOOZE_S - 1))
                        state_nx = ST_RING;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Seconds restart on every state change, so entry-cycle ticks are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            alarm_q  <= 1'b0;
            sec      <= '0;
            sound    <= 1'b0;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
            beep_led <= 1'b0;
        end else begin
            state   <= state_nx;
            alarm_q <= alarm_in;
            if (state_nx != state)
                sec <= '0;
            else if (tick_1hz && state != ST_IDLE)
                sec <= sec + SW'(1);
            sound    <= in_ring & tone_q & beep_on;
            ringing  <= in_ring;
            snoozing <= (state == ST_SNOOZE);
            beep_led <= in_ring & beep_on;
        end
    end

    tone_divider #(
        .DIV  (TONE_DIV),
        .INIT (1'b0)
    ) u_tone (
        .clk   (clk),
        .rst   (rst),
        .clear (ring_entry),
        .en    (in_ring),
        .q     (tone_q)
    );

    tone_divider #(
        .DIV  (BEEP_DIV),
        .INIT (1'b1)
    ) u_beep (
        .clk   (clk),
        .rst   (rst),
        .clear (ring_entry),
        .en    (in_ring),
        .q     (beep_on)
    );

endmodule

// File: tb/tb_alarm_tone_sequencer.sv
// Randomised and directed checks of alarm_tone_sequencer against
// an elapsed-cycle reference model.
module tb_alarm_tone_sequencer;

    localparam int TD = 4;
    localparam int BD = 16;
    localparam int TO = 3;
    localparam int SN = 2;

    localparam int M_IDLE = 0;
    localparam int M_RING = 1;
    localparam int M_SNZ  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic alarm_in = 1'b0;
    logic snooze = 1'b0;
    logic stop = 1'b0;
    logic tick_1hz = 1'b0;
    logic sound, ringing, snoozing, beep_led;

    int n_cmp = 0;
    int n_err = 0;
    int tcnt = 0;

    int m = M_IDLE;
    int k = 0;
    int t = 0;
    logic aq = 1'b0;
    logic [3:0] exp_o = 4'b0;

    alarm_tone_sequencer #(
        .TONE_DIV  (TD),
        .BEEP_DIV  (BD),
        .TIMEOUT_S (TO),
        .SNOOZE_S  (SN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .alarm_in (alarm_in),
        .snooze   (snooze),
        .stop     (stop),
        .tick_1hz (tick_1hz),
        .sound    (sound),
        .ringing  (ringing),
        .snoozing (snoozing),
        .beep_led (beep_led)
    );

    always #5 clk = ~clk;

    // Outputs after an edge reflect the mode and ring age before it;
    // k is the number of RING cycles elapsed since the last entry.
    task automatic model_step();
        logic rise;
        logic tone, beep;
        if (rst) begin
            exp_o = 4'b0;
            m = M_IDLE; aq = 1'b0; k = 0; t = 0;
            return;
        end
        tone = ((k / TD) % 2) == 1;
        beep = ((k / BD) % 2) == 0;
        exp_o = {m == M_RING && tone && beep, m == M_RING,
                 m == M_SNZ, m == M_RING && beep};
        rise = alarm_in && !aq;
        aq = alarm_in;
        if (!enable) begin
            m = M_IDLE;
        end else if (m == M_IDLE) begin
            if (rise) begin m = M_RING; k = 0; t = 0; end
        end else if (m == M_RING) begin
            k++;
            if (stop) m = M_IDLE;
            else if (snooze) begin m = M_SNZ; t = 0; end
            else if (tick_1hz) begin
                t++;
                if (t == TO) m = M_IDLE;
            end
        end else begin
            if (stop) m = M_IDLE;
            else if (tick_1hz) begin
                t++;
                if (t == SN) begin m = M_RING; k = 0; t = 0; end
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        tick_1hz = (tcnt == 99);
        tcnt = (tcnt + 1) % 100;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        n_cmp++;
        if ({sound, ringing, snoozing, beep_led} !== 4'b0) begin
            n_err++;
            $display("FAIL reset: got %b want 0000",
                     {sound, ringing, snoozing, beep_led});
        end
        rst = 1'b0;
    endtask

    task automatic test_ring_timeout();
        alarm_in = 1'b1;
        cyc();
        cyc();
        n_cmp++;
        if (ringing !== 1'b1) begin
            n_err++;
            $display("FAIL ring_start: ringing got %b want 1", ringing);
        end
        repeat (350) begin
            cyc();
            n_cmp++;
            if ({sound, ringing, snoozing, beep_led} !== exp_o) begin
                n_err++;
                $display("FAIL ring_timeout: got %b want %b at %0t",
                         {sound, ringing, snoozing, beep_led}, exp_o, $time);
            end
        end
        n_cmp++;
        if (ringing !== 1'b0) begin
            n_err++;
            $display("FAIL no_retrigger: ringing got %b want 0", ringing);
        end
        alarm_in = 1'b0;
        cyc();
    endtask

    task automatic test_snooze();
        alarm_in = 1'b1;
        repeat (25) cyc();
        snooze = 1'b1;
        cyc();
        snooze = 1'b0;
        cyc();
        n_cmp++;
        if ({snoozing, sound, ringing} !== 3'b100) begin
            n_err++;
            $display("FAIL snooze_enter: got %b want 100",
                     {snoozing, sound, ringing});
        end
        repeat (560) begin
            cyc();
            n_cmp++;
            if ({sound, ringing, snoozing, beep_led} !== exp_o) begin
                n_err++;
                $display("FAIL snooze_cycle: got %b want %b at %0t",
                         {sound, ringing, snoozing, beep_led}, exp_o, $time);
            end
        end
        n_cmp++;
        if ({ringing, snoozing} !== 2'b00) begin
            n_err++;
            $display("FAIL snooze_timeout: got %b want 00",
                     {ringing, snoozing});
        end
        alarm_in = 1'b0;
        cyc();
    endtask

    task automatic test_stop();
        for (int pass = 0; pass < 2; pass++) begin
            alarm_in = 1'b0;
            cyc();
            alarm_in = 1'b1;
            repeat (10) cyc();
            if (pass == 1) begin
                snooze = 1'b1; cyc(); snooze = 1'b0;
                repeat (5) cyc();
            end
            stop = 1'b1;
            cyc();
            stop = 1'b0;
            repeat (3) begin
                cyc();
                n_cmp++;
                if ({sound, ringing, snoozing, beep_led} !== exp_o) begin
                    n_err++;
                    $display("FAIL stop_%0d: got %b want %b", pass,
                             {sound, ringing, snoozing, beep_led}, exp_o);
                end
            end
        end
        alarm_in = 1'b0;
        cyc();
        alarm_in = 1'b1;
        cyc(); cyc();
        n_cmp++;
        if (ringing !== 1'b1) begin
            n_err++;
            $display("FAIL stop_rearm: ringing got %b want 1", ringing);
        end
    endtask

    task automatic test_both_and_rst();
        repeat (7) cyc();
        stop = 1'b1; snooze = 1'b1;
        cyc();
        stop = 1'b0; snooze = 1'b0;
        cyc();
        n_cmp++;
        if ({ringing, snoozing} !== 2'b00 || exp_o[2:1] !== 2'b00) begin
            n_err++;
            $display("FAIL stop_snooze: got %b want 00", {ringing, snoozing});
        end
        alarm_in = 1'b0; cyc();
        alarm_in = 1'b1;
        repeat (13) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++;
        if ({sound, ringing, snoozing, beep_led} !== 4'b0) begin
            n_err++;
            $display("FAIL rst_mid_ring: got %b want 0000",
                     {sound, ringing, snoozing, beep_led});
        end
        alarm_in = 1'b0;
        cyc();
    endtask

    task automatic test_enable();
        alarm_in = 1'b1;
        repeat (9) cyc();
        enable = 1'b0;
        repeat (4) cyc();
        enable = 1'b1;
        repeat (20) begin
            cyc();
            n_cmp++;
            if (ringing !== 1'b0 || exp_o[2] !== 1'b0) begin
                n_err++;
                $display("FAIL enable_hold: ringing got %b want 0", ringing);
            end
        end
        alarm_in = 1'b0; cyc();
        alarm_in = 1'b1; cyc(); cyc();
        n_cmp++;
        if (ringing !== 1'b1) begin
            n_err++;
            $display("FAIL enable_rearm: ringing got %b want 1", ringing);
        end
    endtask

    task automatic test_random();
        repeat (3000) begin
            if ($urandom_range(0, 149) == 0) alarm_in = ~alarm_in;
            snooze = ($urandom_range(0, 199) == 0);
            stop   = ($urandom_range(0, 399) == 0);
            enable = ($urandom_range(0, 499) != 0);
            rst    = ($urandom_range(0, 1499) == 0);
            cyc();
            n_cmp++;
            if ({sound, ringing, snoozing, beep_led} !== exp_o) begin
                n_err++;
                $display("FAIL random: got %b want %b at %0t",
                         {sound, ringing, snoozing, beep_led}, exp_o, $time);
            end
        end
        rst = 1'b0; snooze = 1'b0; stop = 1'b0; enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ring_timeout();
        test_snooze();
        test_stop();
        test_both_and_rst();
        test_enable();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
